// File: rtl/inst_queue_if.sv
// Handshake and decoded-field bundle for the instruction prefetch queue.
// master drives fetch words and consumes the head; slave is the queue.
interface inst_queue_if #(
  parameter int DEPTH = 4,
  parameter int EXT_W = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       ra;
  logic [4:0]       rb;
  logic [4:0]       wr1;
  logic [4:0]       wr2;
  logic [15:0]      imm16;
  logic [EXT_W-1:0] imm_ext;
  logic [25:0]      address;
  logic [31:0]      pc;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_inst, in_pc,
    output out_ready,
    input  in_ready, out_valid,
    input  opcode, funct, ra, rb, wr1, wr2,
    input  imm16, imm_ext, address, pc, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc,
    input  out_ready,
    output in_ready, out_valid,
    output opcode, funct, ra, rb, wr1, wr2,
    output imm16, imm_ext, address, pc, count
  );
endinterface

// File: rtl/inst_queue.sv
// DEPTH-entry instruction prefetch queue presenting the head word
// pre-split into MIPS fields with an extended immediate.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int EXT_W = 32
) (
  input logic       clk,
  input logic       rst,
  inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic [31:0]   head_pc;

  assign q.in_ready  = cnt != FULL;
  assign q.out_valid = cnt != '0;
  assign q.count     = cnt;

  assign push = q.in_valid && q.in_ready;
  assign pop  = q.out_valid && q.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (q.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // storage is never cleared; visibility is governed by cnt alone
  always_ff @(posedge clk) begin
    if (push && !rst && !q.flush) begin
      inst_mem[wp] <= q.in_inst;
      pc_mem[wp]   <= q.in_pc;
    end
  end

  always_comb begin
    head    = '0;
    head_pc = '0;
    if (q.out_valid) begin
      head    = inst_mem[rp];
      head_pc = pc_mem[rp];
    end
  end

  assign q.opcode  = head[31:26];
  assign q.funct   = head[5:0];
  assign q.ra      = head[25:21];
  assign q.rb      = head[20:16];
  assign q.wr1     = head[20:16];
  assign q.wr2     = head[15:11];
  assign q.imm16   = head[15:0];
  assign q.address = head[25:0];
  assign q.pc      = head_pc;

  // andi/ori/xori take a zero-extended immediate
  always_comb begin
    q.imm_ext = '0;
    unique case (head[31:26])
      6'h0C, 6'h0D, 6'h0E:
        q.imm_ext = EXT_W'(head[15:0]);
      default:
        q.imm_ext = EXT_W'($signed(head[15:0]));
    endcase
  end
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed plan items plus random
// traffic checked against a queue-based reference model.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam int EXT_W = 32;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  bit   armed = 1'b0;

  ent_t        sb [$];
  ent_t        e;
  int          n;
  logic [63:0] w, op, imm, ext, mask;

  always #5 clk = ~clk;

  inst_queue_if #(.DEPTH(DEPTH), .EXT_W(EXT_W)) q ();

  inst_queue #(.DEPTH(DEPTH), .EXT_W(EXT_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q.slave)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare against the model, then apply the coming edge
  always @(negedge clk) begin
    if (armed) begin
      n = sb.size();
      chk("count", 64'(q.count), 64'(n));
      chk("out_valid", 64'(q.out_valid), 64'(n != 0));
      chk("in_ready", 64'(q.in_ready), 64'(n < DEPTH));
      e.inst = '0;
      e.pc   = '0;
      if (n != 0) e = sb[0];
      w    = 64'(e.inst);
      op   = (w >> 26) & 64'h3F;
      imm  = w & 64'hFFFF;
      mask = (64'd1 << EXT_W) - 64'd1;
      if (op == 12 || op == 13 || op == 14) ext = imm;
      else if (imm >= 64'h8000) ext = (imm | ~64'hFFFF) & mask;
      else ext = imm;
      chk("opcode", 64'(q.opcode), op);
      chk("funct", 64'(q.funct), w & 64'h3F);
      chk("ra", 64'(q.ra), (w >> 21) & 64'h1F);
      chk("rb", 64'(q.rb), (w >> 16) & 64'h1F);
      chk("wr1", 64'(q.wr1), (w >> 16) & 64'h1F);
      chk("wr2", 64'(q.wr2), (w >> 11) & 64'h1F);
      chk("imm16", 64'(q.imm16), imm);
      chk("imm_ext", 64'(q.imm_ext), ext);
      chk("address", 64'(q.address), w & 64'h3FFFFFF);
      chk("pc", 64'(q.pc), 64'(e.pc));
    end
    if (rst) begin
      sb.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (q.flush) begin
        sb.delete();
      end else begin
        n = sb.size();
        if (n > 0 && q.out_ready) void'(sb.pop_front());
        if (q.in_valid && n < DEPTH) begin
          e.inst = q.in_inst;
          e.pc   = q.in_pc;
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    q.flush     = 1'b0;
    q.in_valid  = 1'b1;
    q.in_inst   = $urandom;
    q.in_pc     = 32'h0;
    q.out_ready = 1'b0;
    step();
    step();
    rst        = 1'b0;
    q.in_valid = 1'b0;
    chk("rst_count", 64'(q.count), 64'd0);
    chk("rst_out_valid", 64'(q.out_valid), 64'd0);
    chk("rst_in_ready", 64'(q.in_ready), 64'd1);
    chk("rst_opcode", 64'(q.opcode), 64'd0);
    chk("rst_imm_ext", 64'(q.imm_ext), 64'd0);

    q.in_valid = 1'b1;
    q.in_inst  = 32'h2128FFFC;
    q.in_pc    = 32'h100;
    step();
    q.in_valid = 1'b0;
    chk("addi_opcode", 64'(q.opcode), 64'h08);
    chk("addi_ra", 64'(q.ra), 64'd9);
    chk("addi_rb", 64'(q.rb), 64'd8);
    chk("addi_wr1", 64'(q.wr1), 64'd8);
    chk("addi_imm16", 64'(q.imm16), 64'hFFFC);
    chk("addi_imm_ext", 64'(q.imm_ext), 64'hFFFFFFFC);
    chk("addi_pc", 64'(q.pc), 64'h100);

    q.in_valid  = 1'b1;
    q.in_inst   = 32'h3508FFFC;
    q.in_pc     = 32'h104;
    q.out_ready = 1'b1;
    step();
    q.in_valid = 1'b0;
    chk("ori_opcode", 64'(q.opcode), 64'h0D);
    chk("ori_imm_ext", 64'(q.imm_ext), 64'h0000FFFC);
    chk("ori_pc", 64'(q.pc), 64'h104);
    step();
    q.out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      q.in_valid = 1'b1;
      q.in_inst  = $urandom;
      q.in_pc    = 32'h200 + 32'(4 * i);
      step();
    end
    q.in_valid = 1'b0;
    chk("full_count", 64'(q.count), 64'd4);
    chk("full_in_ready", 64'(q.in_ready), 64'd0);
    chk("full_head_pc", 64'(q.pc), 64'h200);

    q.in_valid  = 1'b1;
    q.out_ready = 1'b1;
    q.in_inst   = $urandom;
    q.in_pc     = 32'h300;
    step();
    q.in_valid  = 1'b0;
    q.out_ready = 1'b0;
    chk("fullpop_count", 64'(q.count), 64'd3);
    chk("fullpop_head_pc", 64'(q.pc), 64'h204);

    q.flush     = 1'b1;
    q.in_valid  = 1'b1;
    q.out_ready = 1'b1;
    q.in_pc     = 32'h400;
    step();
    q.flush     = 1'b0;
    q.in_valid  = 1'b0;
    q.out_ready = 1'b0;
    chk("flush_count", 64'(q.count), 64'd0);
    chk("flush_out_valid", 64'(q.out_valid), 64'd0);
    q.in_valid = 1'b1;
    q.in_inst  = $urandom;
    q.in_pc    = 32'h500;
    step();
    q.in_valid = 1'b0;
    chk("postflush_pc", 64'(q.pc), 64'h500);
    chk("postflush_count", 64'(q.count), 64'd1);

    q.out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      q.in_valid = 1'b1;
      q.in_inst  = $urandom;
      q.in_pc    = 32'h1000 + 32'(4 * i);
      step();
    end
    q.in_valid = 1'b0;
    chk("stream_count", 64'(q.count), 64'd1);
    chk("stream_last_pc", 64'(q.pc), 64'h1000 + 64'(4 * 3 * DEPTH));
    step();
    chk("drain_count", 64'(q.count), 64'd0);

    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(99) == 0);
      q.flush     = ($urandom_range(31) == 0);
      q.in_valid  = ($urandom_range(9) < 7);
      q.out_ready = ($urandom_range(9) < 6);
      q.in_inst   = $urandom;
      q.in_pc     = $urandom;
      step();
    end
    rst         = 1'b0;
    q.flush     = 1'b0;
    q.in_valid  = 1'b0;
    q.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("final_count", 64'(q.count), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised instruction register for the multi-cycle CPU: a DEPTH-entry instruction prefetch queue that sits between instruction memory and the control unit / register file. It accepts fetched words with their PC over a valid/ready handshake, holds them in order, and presents the head entry pre-split into MIPS fields (opcode, funct, ra, rb, wr1, wr2, imm16, address) plus an extended immediate. Flush discards all queued words on a taken branch or jump.

## Interface
- DEPTH, 4: queue entries; power of two, 2..64.
- EXT_W, 32: width of the extended immediate output; must be at least 16.
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  fetch word present.
- in_inst  in  32  fetched instruction word.
- in_pc  in  32  PC of in_inst.
- in_ready  out  1  queue can accept; equals count < DEPTH.
- out_valid  out  1  head entry valid; equals count != 0.
- out_ready  in  1  consumer takes head (IRWrite-style advance).
- opcode  out  6  head[31:26].
- funct  out  6  head[5:0].
- ra  out  5  head[25:21].
- rb  out  5  head[20:16].
- wr1  out  5  head[20:16].
- wr2  out  5  head[15:11].
- imm16  out  16  head[15:0].
- imm_ext  out  EXT_W  head[15:0] extended; see Operation.
- address  out  26  head[25:0].
- pc  out  32  PC of head entry.
- count  out  $clog2(DEPTH+1)  entries held.

## Operation
- Storage: circular buffer of DEPTH {inst, pc} pairs. It uses write pointer wp and read pointer rp, each $clog2(DEPTH) bits, which wrap modulo DEPTH naturally. count is a registered value.
- Push: occurs when in_valid && in_ready. The entry is written at wp, and wp increments.
- Pop: occurs when out_valid && out_ready. rp increments.
- Simultaneous push and pop when 0 < count < DEPTH: both actions take effect, and count is unchanged.
- Full (count == DEPTH): in_ready = 0. There is no push, even if a pop happens in the same cycle. There is no full-bypass path.
- Empty (count == 0): out_valid = 0. out_ready is ignored. A push on an empty queue is not visible until the next cycle. There is no empty-bypass path.
- Flush: wp, rp and count go to 0 at the edge. flush overrides push and pop in the same cycle. The word offered in that cycle is dropped, even though in_ready was 1.
- Field outputs: combinational slices of the entry at rp. When out_valid = 0, all field outputs, imm_ext and pc are forced to 0.
- imm_ext: zero-extended when opcode is 0x0C (andi), 0x0D (ori) or 0x0E (xori). Otherwise it is sign-extended from bit 15.
- Head stability: while out_valid && !out_ready, every field output holds constant, regardless of pushes.
- in_ready, out_valid and count derive only from registered state. They do not depend combinationally on in_valid, out_ready or flush.

## Timing
- rst at an edge sets wp = rp = count = 0. It therefore sets in_ready = 1, out_valid = 0, and all field outputs, imm_ext, pc and count to 0. rst has priority over flush, push and pop.
- rst asserted mid-stream discards all contents. The storage array itself is not cleared.
- Push-to-visible latency: 1 cycle. A push at edge N makes out_valid high after edge N and the fields valid in cycle N+1.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Pop at edge N: the next entry (or zeros if the queue becomes empty) appears after edge N.
- Order: strictly FIFO across pointer wrap-around.

## Test plan
- Reset/empty: assert rst 2 cycles with in_valid = 1 -> after release count = 0, out_valid = 0, in_ready = 1, opcode = 0, imm_ext = 0.
- Decode: push 0x2128FFFC (addi, pc = 0x100) -> next cycle opcode = 0x08, ra = 9, rb = 8, wr1 = 8, imm16 = 0xFFFC, imm_ext = 0xFFFFFFFC, pc = 0x100. Then push 0x3508FFFC (ori) -> imm_ext = 0x0000FFFC.
- Fill/full: DEPTH = 4, push 5 words back-to-back with out_ready = 0 -> in_ready falls after the 4th push, the 5th word is not accepted, count = 4. Head stays word 0 throughout.
- Wrap and stream: with out_ready = 1 and in_valid = 1, stream 3*DEPTH+1 sequential words -> words pop in exact order with no loss, and count stays at 1 in steady state.
- Full with pop: with count = 4, assert out_ready and in_valid in the same cycle -> pop only, count = 3, the offered word is not taken.
- Flush: with count = 3, assert flush, in_valid and out_ready together -> next cycle count = 0, out_valid = 0. The offered word is absent, and the next pushed word appears at the head.
